// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I funct3 encodings,
// the controller state type and small request-decoding helpers.
package lsu_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      WAIT   = 2'd2,
      RESP   = 2'd3
   } lsu_state_e;

   // Stores only know B/H/W; the unsigned variants exist for loads only.
   function automatic logic f3_legal(input logic we, input logic [2:0] f3);
      if (we)
         return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
      else
         return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
                (f3 == F3_BU) || (f3 == F3_HU);
   endfunction

   function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] lo);
      return (((f3 == F3_H) || (f3 == F3_HU)) && lo[0]) ||
             ((f3 == F3_W) && (lo != 2'b00));
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane alignment for the load/store unit.
//   store_mode  1: replicate store data across lanes and build byte enables
//               0: extract the addressed byte/half of a RAM word and extend
//   funct3      RV32I access size/signedness
//   addr_lo     byte offset within the word
//   data_in     store data (low bits) or RAM read word
//   data_out    lane-shifted store data or extended load result
//   byte_en     per-byte write enable (store mode only, else 0)
module lsu_align
   import lsu_pkg::*;
(
   input  logic        store_mode,
   input  logic [2:0]  funct3,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] data_in,
   output logic [31:0] data_out,
   output logic [3:0]  byte_en
);

   logic [31:0] shifted;
   logic [7:0]  b_sel;
   logic [15:0] h_sel;

   assign shifted = data_in >> {addr_lo, 3'b000};
   assign b_sel   = shifted[7:0];
   assign h_sel   = addr_lo[1] ? data_in[31:16] : data_in[15:0];

   always_comb begin
      data_out = '0;
      byte_en  = '0;
      if (store_mode) begin
         case (funct3)
            F3_B: begin
               byte_en  = 4'b0001 << addr_lo;
               data_out = {4{data_in[7:0]}};
            end
            F3_H: begin
               byte_en  = 4'b0011 << addr_lo;
               data_out = {2{data_in[15:0]}};
            end
            F3_W: begin
               byte_en  = 4'b1111;
               data_out = data_in;
            end
            default: ;
         endcase
      end else begin
         case (funct3)
            F3_B:    data_out = {{24{b_sel[7]}}, b_sel};
            F3_BU:   data_out = {24'd0, b_sel};
            F3_H:    data_out = {{16{h_sel[15]}}, h_sel};
            F3_HU:   data_out = {16'd0, h_sel};
            F3_W:    data_out = data_in;
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/lsu.sv
// Load/store unit in front of a word-addressed data RAM with 1-cycle
// registered read and per-byte write enables. One request at a time.
//   clk, rst                  clock, synchronous active-high reset
//   req_*                     execute-stage request (valid/ready)
//   resp_*                    response (valid/ready), rdata/err held in RESP
//   mem_r_addr / mem_r_val    RAM read port
//   mem_w_enable / mem_w_addr / mem_w_val / mem_byte_en   RAM write port
//
// state  | meaning
// IDLE   | ready for a request
// ACCESS | request latched; drive RAM read or write, or flag error
// WAIT   | RAM read data available; align and extend
// RESP   | response presented until consumer takes it
module lsu
   import lsu_pkg::*;
#(
   parameter int unsigned MEM_WORDS = 500
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic [29:0] mem_r_addr,
   input  logic [31:0] mem_r_val,
   output logic        mem_w_enable,
   output logic [29:0] mem_w_addr,
   output logic [31:0] mem_w_val,
   output logic [3:0]  mem_byte_en
);

   lsu_state_e  state_q, state_d;
   logic        we_q;
   logic [2:0]  f3_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [31:0] rdata_q;
   logic        err_q;
   logic [29:0] r_addr_q;

   logic        acc_err;
   logic        store_go;
   logic        load_go;
   logic [31:0] al_data;
   logic [3:0]  al_be;

   assign acc_err = !f3_legal(we_q, f3_q) ||
                    f3_misaligned(f3_q, addr_q[1:0]) ||
                    ({2'b00, addr_q[31:2]} >= MEM_WORDS);

   // rst gating: the RAM writes on byte_en alone, so a reset landing in
   // ACCESS must not let the strobe through.
   assign store_go = (state_q == ACCESS) && we_q && !acc_err && !rst;
   assign load_go  = (state_q == ACCESS) && !we_q && !acc_err;

   lsu_align u_align (
      .store_mode (we_q),
      .funct3     (f3_q),
      .addr_lo    (addr_q[1:0]),
      .data_in    (we_q ? wdata_q : mem_r_val),
      .data_out   (al_data),
      .byte_en    (al_be)
   );

   always_ff @(posedge clk) begin
      if (rst)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (req_valid) state_d = ACCESS;
         ACCESS:  state_d = (acc_err || we_q) ? RESP : WAIT;
         WAIT:    state_d = RESP;
         RESP:    if (resp_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      req_ready    = (state_q == IDLE);
      resp_valid   = (state_q == RESP);
      mem_w_enable = store_go;
      mem_w_addr   = '0;
      mem_w_val    = '0;
      mem_byte_en  = '0;
      if (store_go) begin
         mem_w_addr  = addr_q[31:2];
         mem_w_val   = al_data;
         mem_byte_en = al_be;
      end
      mem_r_addr = load_go ? addr_q[31:2] : r_addr_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         we_q     <= 1'b0;
         f3_q     <= '0;
         addr_q   <= '0;
         wdata_q  <= '0;
         rdata_q  <= '0;
         err_q    <= 1'b0;
         r_addr_q <= '0;
      end else begin
         if ((state_q == IDLE) && req_valid) begin
            we_q    <= req_we;
            f3_q    <= req_funct3;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
         end
         if (load_go)
            r_addr_q <= addr_q[31:2];
         case (state_q)
            ACCESS: begin
               if (acc_err || we_q) begin
                  rdata_q <= '0;
                  err_q   <= acc_err;
               end
            end
            WAIT: begin
               rdata_q <= al_data;
               err_q   <= 1'b0;
            end
            RESP: begin
               if (resp_ready) begin
                  rdata_q <= '0;
                  err_q   <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   assign resp_rdata = rdata_q;
   assign resp_err   = err_q;

endmodule

// File: tb/tb_lsu.sv
module tb_lsu;
   import lsu_pkg::*;

   localparam int MW = 500;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_ready, req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr, req_wdata;
   logic        resp_valid, resp_ready, resp_err;
   logic [31:0] resp_rdata;
   logic [29:0] mem_r_addr, mem_w_addr;
   logic [31:0] mem_r_val, mem_w_val;
   logic        mem_w_enable;
   logic [3:0]  mem_byte_en;

   always #5 clk = ~clk;

   lsu #(.MEM_WORDS(MW)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_rdata(resp_rdata), .resp_err(resp_err),
      .mem_r_addr(mem_r_addr), .mem_r_val(mem_r_val),
      .mem_w_enable(mem_w_enable), .mem_w_addr(mem_w_addr),
      .mem_w_val(mem_w_val), .mem_byte_en(mem_byte_en)
   );

   // RAM: writes on byte_en alone, registered read
   logic [31:0] ram [0:MW-1];
   logic [31:0] ram_rd;
   always @(posedge clk) begin
      for (int b = 0; b < 4; b++)
         if (mem_byte_en[b] && (32'(mem_w_addr) < MW))
            ram[mem_w_addr[8:0]][8*b +: 8] <= mem_w_val[8*b +: 8];
      if (32'(mem_r_addr) < MW) ram_rd <= ram[mem_r_addr[8:0]];
      else                      ram_rd <= 32'hBAD0BAD0;
   end
   assign mem_r_val = ram_rd;

   logic [31:0] ref_mem [0:MW-1];
   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: architectural effect of one access on a word array.
   task automatic model_op(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata, output logic [31:0] rd, output logic err,
                           output logic [3:0] be, output logic [31:0] wv);
      int unsigned idx, lo, sz;
      logic [31:0] mask;
      logic legal;
      idx = addr / 4;
      lo  = addr % 4;
      sz  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
      legal = we ? (f3 <= 3'd2) : ((f3 != 3'd3) && (f3 < 3'd6));
      err = !legal || ((lo % sz) != 0) || (idx >= MW);
      rd = 0; be = 0; wv = 0;
      if (!err) begin
         mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8*sz)) - 1);
         if (we) begin
            be = 4'(((1 << sz) - 1) << lo);
            wv = (sz == 1) ? (wdata & 32'hFF) * 32'h0101_0101 :
                 (sz == 2) ? (wdata & 32'hFFFF) * 32'h0001_0001 : wdata;
            ref_mem[idx] = (ref_mem[idx] & ~(mask << (8*lo))) | ((wdata & mask) << (8*lo));
         end else begin
            rd = (ref_mem[idx] >> (8*lo)) & mask;
            if ((f3 < 3'd4) && (sz < 4) && rd[8*sz-1]) rd = rd | ~mask;
         end
      end
   endtask

   task automatic run_op(input string tag, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_rd, input logic exp_err,
                         input logic [3:0] exp_be, input logic [31:0] exp_wv, input int hold);
      int cyc, waitc;
      @(negedge clk);
      req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
      resp_ready = (hold == 0);
      waitc = 0;
      while (!req_ready && waitc < 20) begin
         @(negedge clk);
         waitc++;
      end
      if (waitc >= 20) check({tag, " accept_timeout"}, 32'(req_ready), 32'd1);
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      check({tag, " access_req_ready"}, 32'(req_ready), 32'd0);
      check({tag, " access_resp_valid"}, 32'(resp_valid), 32'd0);
      check({tag, " access_byte_en"}, 32'(mem_byte_en), 32'(exp_be));
      check({tag, " access_w_enable"}, 32'(mem_w_enable), 32'(we && !exp_err));
      if (we && !exp_err) begin
         check({tag, " w_addr"}, 32'(mem_w_addr), addr >> 2);
         check({tag, " w_val"}, mem_w_val, exp_wv);
      end
      if (!we && !exp_err) check({tag, " r_addr"}, 32'(mem_r_addr), addr >> 2);
      cyc = 1;
      while (!resp_valid && cyc < 8) begin
         @(negedge clk);
         cyc++;
         check({tag, " later_byte_en"}, 32'(mem_byte_en), 32'd0);
      end
      check({tag, " latency"}, 32'(cyc), (we || exp_err) ? 32'd2 : 32'd3);
      check({tag, " rdata"}, resp_rdata, exp_rd);
      check({tag, " err"}, 32'(resp_err), 32'(exp_err));
      if (hold > 0) begin
         repeat (hold) begin
            @(negedge clk);
            check({tag, " hold_valid"}, 32'(resp_valid), 32'd1);
            check({tag, " hold_ready"}, 32'(req_ready), 32'd0);
            check({tag, " hold_rdata"}, resp_rdata, exp_rd);
            check({tag, " hold_err"}, 32'(resp_err), 32'(exp_err));
         end
         resp_ready = 1'b1;
      end
      @(negedge clk);
      check({tag, " done_valid"}, 32'(resp_valid), 32'd0);
      check({tag, " done_ready"}, 32'(req_ready), 32'd1);
   endtask

   typedef struct {
      string       name;
      logic        we;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rd;
      logic        exp_err;
   } vec_t;

   vec_t tbl [15];

   initial begin
      logic [31:0] m_rd, m_wv;
      logic        m_err;
      logic [3:0]  m_be;
      int          bad;

      tbl[0]  = '{"lw_10",     1'b0, F3_W,   32'h10,  32'h0,         32'hDEAD_BEEF, 1'b0};
      tbl[1]  = '{"sw_10",     1'b1, F3_W,   32'h10,  32'h80FF_7F01, 32'h0,         1'b0};
      tbl[2]  = '{"lb_13",     1'b0, F3_B,   32'h13,  32'h0,         32'hFFFF_FF80, 1'b0};
      tbl[3]  = '{"lbu_13",    1'b0, F3_BU,  32'h13,  32'h0,         32'h0000_0080, 1'b0};
      tbl[4]  = '{"lh_12",     1'b0, F3_H,   32'h12,  32'h0,         32'hFFFF_80FF, 1'b0};
      tbl[5]  = '{"lhu_10",    1'b0, F3_HU,  32'h10,  32'h0,         32'h0000_7F01, 1'b0};
      tbl[6]  = '{"sh_06",     1'b1, F3_H,   32'h06,  32'h0000_ABCD, 32'h0,         1'b0};
      tbl[7]  = '{"lw_04",     1'b0, F3_W,   32'h04,  32'h0,         32'hABCD_3344, 1'b0};
      tbl[8]  = '{"lw_0a_mis", 1'b0, F3_W,   32'h0A,  32'h0,         32'h0,         1'b1};
      tbl[9]  = '{"sh_03_mis", 1'b1, F3_H,   32'h03,  32'h1234,      32'h0,         1'b1};
      tbl[10] = '{"sw_oor",    1'b1, F3_W,   32'h7D0, 32'h5555_5555, 32'h0,         1'b1};
      tbl[11] = '{"lw_last",   1'b0, F3_W,   32'h7CC, 32'h0,         32'h01F3_FE0C, 1'b0};
      tbl[12] = '{"ld_f3_011", 1'b0, 3'b011, 32'h0,   32'h0,         32'h0,         1'b1};
      tbl[13] = '{"st_f3_100", 1'b1, 3'b100, 32'h0,   32'hFFFF_FFFF, 32'h0,         1'b1};
      tbl[14] = '{"lb_00",     1'b0, F3_B,   32'h0,   32'h0,         32'hFFFF_FFFF, 1'b0};

      for (int i = 0; i < MW; i++) begin
         ram[i]     = {16'(i), ~16'(i)};
         ref_mem[i] = {16'(i), ~16'(i)};
      end
      ram[1] = 32'h1122_3344; ref_mem[1] = 32'h1122_3344;
      ram[4] = 32'hDEAD_BEEF; ref_mem[4] = 32'hDEAD_BEEF;

      rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0;
      req_addr = '0; req_wdata = '0; resp_ready = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_req_ready", 32'(req_ready), 32'd1);
      check("rst_resp_valid", 32'(resp_valid), 32'd0);
      check("rst_rdata", resp_rdata, 32'd0);
      check("rst_err", 32'(resp_err), 32'd0);
      check("rst_w_enable", 32'(mem_w_enable), 32'd0);
      check("rst_byte_en", 32'(mem_byte_en), 32'd0);
      check("rst_r_addr", 32'(mem_r_addr), 32'd0);
      check("rst_w_addr", 32'(mem_w_addr), 32'd0);
      check("rst_w_val", mem_w_val, 32'd0);
      rst = 1'b0;

      for (int i = 0; i < 15; i++) begin
         model_op(tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wdata, m_rd, m_err, m_be, m_wv);
         run_op(tbl[i].name, tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wdata,
                tbl[i].exp_rd, tbl[i].exp_err, m_be, m_wv, 0);
      end

      // response held off for 5 cycles
      model_op(1'b0, F3_W, 32'h10, 32'h0, m_rd, m_err, m_be, m_wv);
      run_op("lw_hold", 1'b0, F3_W, 32'h10, 32'h0, m_rd, m_err, m_be, m_wv, 5);

      // reset during store ACCESS: no write, no response
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_funct3 = F3_W;
      req_addr = 32'h20; req_wdata = 32'h1234_5678; resp_ready = 1'b1;
      @(posedge clk);
      #1 req_valid = 1'b0; rst = 1'b1;
      @(negedge clk);
      check("rstacc_byte_en", 32'(mem_byte_en), 32'd0);
      check("rstacc_w_enable", 32'(mem_w_enable), 32'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      repeat (3) begin
         @(negedge clk);
         check("rstacc_resp_valid", 32'(resp_valid), 32'd0);
         check("rstacc_req_ready", 32'(req_ready), 32'd1);
      end
      check("rstacc_word8", ram[8], ref_mem[8]);

      // randomized traffic against the model
      for (int n = 0; n < 200; n++) begin
         logic        we;
         logic [2:0]  f3;
         logic [31:0] addr, wdata;
         int          hold;
         we = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 3) != 0) begin
            if (we) f3 = 3'($urandom_range(0, 2));
            else begin
               f3 = 3'($urandom_range(0, 4));
               if (f3 == 3'd3) f3 = F3_HU;
            end
         end else f3 = 3'($urandom_range(0, 7));
         case ($urandom_range(0, 7))
            0:       addr = $urandom;
            1:       addr = 32'(MW*4 - 4) + 32'($urandom_range(0, 7));
            default: addr = 32'($urandom_range(0, MW*4 - 1));
         endcase
         if ($urandom_range(0, 2) != 0) begin
            if (f3[1:0] == 2'd1) addr[0] = 1'b0;
            if (f3[1:0] == 2'd2) addr[1:0] = 2'b00;
         end
         wdata = $urandom;
         hold  = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 3) : 0;
         model_op(we, f3, addr, wdata, m_rd, m_err, m_be, m_wv);
         run_op($sformatf("rnd%0d", n), we, f3, addr, wdata, m_rd, m_err, m_be, m_wv, hold);
      end

      bad = 0;
      for (int i = 0; i < MW; i++)
         if (ram[i] !== ref_mem[i]) bad++;
      check("ram_vs_model_words", 32'(bad), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
